// File: rtl/uart_pkg.sv
// Shared definitions for the UART frame receiver: byte FSM states and
// bit-timing helpers.
package uart_pkg;

  localparam int unsigned DATA_BITS = 8;

  typedef enum logic [1:0] {
    IDLE,
    START,
    DATA,
    STOP
  } byte_state_e;

  function automatic int unsigned bit_cycles(input int unsigned clk_freq,
                                             input int unsigned baud);
    return clk_freq / baud;
  endfunction

endpackage

// File: rtl/uart_byte_rx.sv
// 8N1 byte deserialiser: input synchroniser, start/data/stop FSM and
// baud/bit counters. Reports each byte as a one-cycle valid or error pulse.
module uart_byte_rx
  import uart_pkg::*;
#(
  parameter int unsigned CLK_FREQ = 50_000_000,
  parameter int unsigned BAUD     = 115200
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 rx_i,
  output logic                 byte_valid,
  output logic [DATA_BITS-1:0] byte_data,
  output logic                 byte_err,
  output logic                 line_idle,
  output logic                 start_edge
);

  localparam int unsigned BIT_CYC  = bit_cycles(CLK_FREQ, BAUD);
  localparam int unsigned HALF_CYC = BIT_CYC / 2;
  localparam int unsigned CW       = $clog2(BIT_CYC);
  localparam int unsigned IW       = $clog2(DATA_BITS);

  localparam logic [CW-1:0] BIT_LAST  = CW'(BIT_CYC - 1);
  localparam logic [CW-1:0] HALF_LAST = CW'(HALF_CYC - 1);
  localparam logic [IW-1:0] IDX_LAST  = IW'(DATA_BITS - 1);

  logic sync1_q, sync2_q, prev_q;
  logic fall;

  byte_state_e          state_q, state_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic [IW-1:0]        bit_idx_q, bit_idx_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;

  // sync2_q is the sampled line; prev_q delays it once more for edge detection
  assign fall = prev_q & ~sync2_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      sync1_q   <= 1'b1;
      sync2_q   <= 1'b1;
      prev_q    <= 1'b1;
      state_q   <= IDLE;
      cnt_q     <= '0;
      bit_idx_q <= '0;
      shift_q   <= '0;
    end else begin
      sync1_q   <= rx_i;
      sync2_q   <= sync1_q;
      prev_q    <= sync2_q;
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      bit_idx_q <= bit_idx_d;
      shift_q   <= shift_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    bit_idx_d  = bit_idx_q;
    shift_d    = shift_q;
    byte_valid = 1'b0;
    byte_err   = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (fall) begin
          state_d = START;
          cnt_d   = '0;
        end
      end
      START: begin
        if (cnt_q == HALF_LAST) begin
          cnt_d     = '0;
          bit_idx_d = '0;
          state_d   = sync2_q ? IDLE : DATA;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      DATA: begin
        if (cnt_q == BIT_LAST) begin
          cnt_d   = '0;
          shift_d = {sync2_q, shift_q[DATA_BITS-1:1]};
          if (bit_idx_q == IDX_LAST) begin
            state_d = STOP;
          end else begin
            bit_idx_d = bit_idx_q + 1'b1;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      STOP: begin
        // Leave at mid-stop-bit so a back-to-back start edge is not missed
        if (cnt_q == BIT_LAST) begin
          cnt_d      = '0;
          state_d    = IDLE;
          byte_valid = sync2_q;
          byte_err   = ~sync2_q;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  assign byte_data  = shift_q;
  assign line_idle  = (state_q == IDLE);
  assign start_edge = line_idle & fall;

endmodule

// File: rtl/uart_frame_rx.sv
// Multi-byte UART frame receiver: collects BYTES consecutive 8N1 bytes into
// one word, discarding partial frames on framing errors or inter-byte timeout.
module uart_frame_rx
  import uart_pkg::*;
#(
  parameter int unsigned CLK_FREQ     = 50_000_000,
  parameter int unsigned BAUD         = 115200,
  parameter int unsigned BYTES        = 5,
  parameter int unsigned TIMEOUT_BITS = 20
) (
  input  logic                 sys_clk,
  input  logic                 rst,
  input  logic                 uart_rx,
  output logic [8*BYTES-1:0]   Data,
  output logic                 frame_done,
  output logic                 frame_err
);

  localparam int unsigned BIT_CYC   = bit_cycles(CLK_FREQ, BAUD);
  localparam int unsigned GAP_LIMIT = TIMEOUT_BITS * BIT_CYC;
  localparam int unsigned FW        = DATA_BITS * BYTES;
  localparam int unsigned CNTW      = $clog2(BYTES + 1);
  localparam int unsigned GW        = $clog2(GAP_LIMIT + 1);

  localparam logic [CNTW-1:0] CNT_LAST = CNTW'(BYTES - 1);
  localparam logic [GW-1:0]   GAP_LAST = GW'(GAP_LIMIT - 1);

  logic                 byte_valid;
  logic [DATA_BITS-1:0] byte_data;
  logic                 byte_err;
  logic                 line_idle;
  logic                 start_edge;

  logic [CNTW-1:0] byte_cnt_q, byte_cnt_d;
  logic [FW-1:0]   slots_q, slots_d;
  logic [GW-1:0]   gap_q, gap_d;
  logic [FW-1:0]   data_q, data_d;
  logic            done_q, done_d;
  logic            err_q, err_d;

  uart_byte_rx #(
    .CLK_FREQ (CLK_FREQ),
    .BAUD     (BAUD)
  ) u_byte_rx (
    .clk_i      (sys_clk),
    .rst_i      (rst),
    .rx_i       (uart_rx),
    .byte_valid (byte_valid),
    .byte_data  (byte_data),
    .byte_err   (byte_err),
    .line_idle  (line_idle),
    .start_edge (start_edge)
  );

  always_ff @(posedge sys_clk) begin
    if (rst) begin
      byte_cnt_q <= '0;
      slots_q    <= '0;
      gap_q      <= '0;
      data_q     <= '0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      byte_cnt_q <= byte_cnt_d;
      slots_q    <= slots_d;
      gap_q      <= gap_d;
      data_q     <= data_d;
      done_q     <= done_d;
      err_q      <= err_d;
    end
  end

  always_comb begin
    byte_cnt_d = byte_cnt_q;
    slots_d    = slots_q;
    gap_d      = gap_q;
    data_d     = data_q;
    done_d     = 1'b0;
    err_d      = 1'b0;

    // Gap timer only runs between bytes of a partially received frame
    if (start_edge || (byte_cnt_q == '0)) begin
      gap_d = '0;
    end else if (line_idle) begin
      if (gap_q == GAP_LAST) begin
        gap_d      = '0;
        err_d      = 1'b1;
        byte_cnt_d = '0;
        slots_d    = '0;
      end else begin
        gap_d = gap_q + 1'b1;
      end
    end

    // Byte pulses only occur outside IDLE, so they never coincide with a timeout
    if (byte_err) begin
      err_d      = 1'b1;
      byte_cnt_d = '0;
      slots_d    = '0;
    end else if (byte_valid) begin
      for (int unsigned i = 0; i < BYTES; i++) begin
        if (byte_cnt_q == CNTW'(i)) begin
          slots_d[i*DATA_BITS +: DATA_BITS] = byte_data;
        end
      end
      if (byte_cnt_q == CNT_LAST) begin
        data_d     = slots_d;
        done_d     = 1'b1;
        byte_cnt_d = '0;
        slots_d    = '0;
      end else begin
        byte_cnt_d = byte_cnt_q + 1'b1;
      end
    end
  end

  assign Data       = data_q;
  assign frame_done = done_q;
  assign frame_err  = err_q;

endmodule
